// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Takes the register-file read operands, computes one M-extension result over
// 32 radix-2 iterations and presents it on the register-file write port. The
// core stalls while Busy is high.
//
// Timing: the Start edge loads the operands and the counter (31). 32 CALC
// edges run the iterations. One more CALC edge forms the signed result into
// WriteData. FINISH then lasts one cycle and pulses Done.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let trivial cases go
// straight from IDLE to FINISH. The trivial cases are a divide by zero, signed
// divide overflow, and a multiply with a zero operand. Results do not change.
//
// Ports:
//   CLK           in   clock, all state on posedge
//   RST_n         in   asynchronous active-low reset
//   Start         in   request, sampled only in IDLE
//   Funct3[2:0]   in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                      100 DIV 101 DIVU 110 REM 111 REMU
//   Operand1      in   rs1 value
//   Operand2      in   rs2 value
//   Rd[4:0]       in   destination register index
//   Busy          out  high in CALC and FINISH
//   Done          out  one-cycle pulse in FINISH
//   WriteData     out  result, held until the next FINISH
//   WriteAddress  out  captured Rd
//   WriteEn       out  Done and captured Rd non-zero
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic [4:0]      Rd,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] WriteData,
    output logic [4:0]      WriteAddress,
    output logic            WriteEn
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              drain;        // all iterations done, result forms next edge
    logic [2:0]        f3_r;
    logic              sa_r, sb_r, dz_r;
    logic [XLEN-1:0]   hi_r, lo_r, b_r;

    // Final sign fix-up and result selection. The accumulator holds either
    // the unsigned product {hi,lo} or the quotient (lo) and remainder (hi).
    function automatic logic [XLEN-1:0] form_result(
        input logic [2:0]      f3,
        input logic            sa,
        input logic            sb,
        input logic            dz,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = {hi, lo};
        if (sa ^ sb) p = -p;
        q = (sa ^ sb) ? -lo : lo;
        if (dz) q = '1;              // divide by zero: all ones, whatever the signs
        r = sa ? -hi : hi;           // remainder follows the dividend
        case (f3)
            3'b000:  form_result = p[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  form_result = p[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  form_result = q;
            default: form_result = r;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        magnitude = neg ? -v : v;
    endfunction

    // Operand decode. Only negative values of signed operands get negated.
    logic            start_acc;
    logic            in_sa, in_sb, neg_a, neg_b, in_dz, in_ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            early_out;
    logic [XLEN-1:0] early_hi, early_lo;

    assign start_acc = (state == S_IDLE) && Start;
    assign in_sa     = Funct3[2] ? !Funct3[0] : (Funct3[1:0] != 2'b11);
    assign in_sb     = Funct3[2] ? !Funct3[0] : !Funct3[1];
    assign neg_a     = in_sa && Operand1[XLEN-1];
    assign neg_b     = in_sb && Operand2[XLEN-1];
    assign abs_a     = magnitude(Operand1, neg_a);
    assign abs_b     = magnitude(Operand2, neg_b);
    assign in_dz     = (Operand2 == '0);
    assign in_ovf    = !Funct3[0] && (Operand1 == MIN_NEG) && (Operand2 == '1);

    // Accumulator contents the full path would reach for the trivial cases.
    assign early_hi  = (Funct3[2] && in_dz) ? abs_a : '0;
    assign early_lo  = !Funct3[2] ? '0 : (in_dz ? '1 : MIN_NEG);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = Funct3[2] ? (in_dz || in_ovf)
                                 : ((Operand1 == '0) || (Operand2 == '0));
`else
    assign early_out = 1'b0 & in_ovf;
`endif

    // Single iteration step, shared registers for both operations.
    logic [XLEN:0] mul_sum, div_sh, div_diff;
    logic          div_ok;

    assign mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign div_sh   = {hi_r, lo_r[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_r};
    assign div_ok   = !div_diff[XLEN];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Start) state_nxt = early_out ? S_FINISH : S_CALC;
            S_CALC:   if (drain) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control and write-port registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt          <= '0;
            drain        <= 1'b0;
            f3_r         <= '0;
            sa_r         <= 1'b0;
            sb_r         <= 1'b0;
            dz_r         <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
        end else if (start_acc) begin
            cnt          <= '1;
            drain        <= 1'b0;
            f3_r         <= Funct3;
            sa_r         <= neg_a;
            sb_r         <= neg_b;
            dz_r         <= in_dz;
            WriteAddress <= Rd;
            if (early_out)
                WriteData <= form_result(Funct3, neg_a, neg_b, in_dz, early_hi, early_lo);
        end else if (state == S_CALC) begin
            if (drain)
                WriteData <= form_result(f3_r, sa_r, sb_r, dz_r, hi_r, lo_r);
            else if (cnt == '0)
                drain <= 1'b1;
            else
                cnt <= cnt - CNT_W'(1);
        end
    end

    // Datapath registers: shift-add multiply / restoring divide.
    always_ff @(posedge CLK) begin
        if (start_acc) begin
            hi_r <= '0;
            lo_r <= abs_a;
            b_r  <= abs_b;
        end else if (state == S_CALC && !drain) begin
            if (!f3_r[2]) begin
                hi_r <= mul_sum[XLEN:1];
                lo_r <= {mul_sum[0], lo_r[XLEN-1:1]};
            end else begin
                hi_r <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                lo_r <= {lo_r[XLEN-2:0], div_ok};
            end
        end
    end

    assign Busy    = (state != S_IDLE);
    assign Done    = (state == S_FINISH);
    assign WriteEn = Done && (WriteAddress != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: expected results are queued as each operation is
// launched and compared, with their Done cycle, when the unit reports them.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] Operand1, Operand2;
    logic [4:0]  Rd;
    logic        Busy, Done, WriteEn;
    logic [31:0] WriteData;
    logic [4:0]  WriteAddress;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_unit dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .Start        (Start),
        .Funct3       (Funct3),
        .Operand1     (Operand1),
        .Operand2     (Operand2),
        .Rd           (Rd),
        .Busy         (Busy),
        .Done         (Done),
        .WriteData    (WriteData),
        .WriteAddress (WriteAddress),
        .WriteEn      (WriteEn)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference behaviour of the RV32M operations.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic signed [31:0] as_, bs_, t;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        as_ = a;
        bs_ = b;
        case (f3)
            3'b000: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[31:0]; end
            3'b001: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            3'b010: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                t = as_ / bs_;
                return t;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                t = as_ % bs_;
                return t;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit early_expected(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2]) return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
`else
        return (f3 == 3'b000) && (a != a);
`endif
    endfunction

    // Launch one operation (call at a negedge). When track is set the expected
    // result and its Done cycle go onto the scoreboard.
    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] exp_data, input bit track,
                            input string name);
        exp_t e;
        Funct3 = f3; Operand1 = a; Operand2 = b; Rd = rd; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        if (track) begin
            e.data = exp_data;
            e.addr = rd;
            e.we   = (rd != 0);
            e.due  = cyc + (early_expected(f3, a, b) ? 0 : 33);
            e.name = name;
            sb.push_back(e);
        end
        Funct3 = 3'($urandom); Operand1 = $urandom; Operand2 = $urandom; Rd = 5'($urandom);
    endtask

    // Consume the scoreboard: each Done pops one entry.
    task automatic collect_results(input int budget);
        exp_t e;
        int   waited;
        waited = 0;
        while (sb.size() > 0 && waited < budget) begin
            if (Done === 1'b1) begin
                e = sb.pop_front();
                tests++;
                if (WriteData !== e.data) begin
                    fails++;
                    $display("FAIL %s data: got %h expected %h", e.name, WriteData, e.data);
                end
                tests++;
                if (WriteAddress !== e.addr) begin
                    fails++;
                    $display("FAIL %s addr: got %0d expected %0d", e.name, WriteAddress, e.addr);
                end
                tests++;
                if (WriteEn !== e.we) begin
                    fails++;
                    $display("FAIL %s wen: got %b expected %b", e.name, WriteEn, e.we);
                end
                tests++;
                if (cyc !== e.due) begin
                    fails++;
                    $display("FAIL %s latency: done at cycle %0d expected %0d", e.name, cyc, e.due);
                end
                @(negedge CLK);
                waited++;
                tests++;
                if (Done !== 1'b0 || WriteEn !== 1'b0) begin
                    fails++;
                    $display("FAIL %s pulse: done=%b wen=%b one cycle later, expected 0/0", e.name, Done, WriteEn);
                end
            end else begin
                @(negedge CLK);
                waited++;
            end
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset;
        RST_n = 1'b0; Start = 1'b0; Funct3 = 3'b000; Operand1 = 32'h0; Operand2 = 32'h0; Rd = 5'd0;
        #1;
        tests++; if (Busy !== 1'b0)         begin fails++; $display("FAIL reset busy: got %b expected 0", Busy); end
        tests++; if (Done !== 1'b0)         begin fails++; $display("FAIL reset done: got %b expected 0", Done); end
        tests++; if (WriteEn !== 1'b0)      begin fails++; $display("FAIL reset wen: got %b expected 0", WriteEn); end
        tests++; if (WriteData !== 32'h0)   begin fails++; $display("FAIL reset data: got %h expected 0", WriteData); end
        tests++; if (WriteAddress !== 5'd0) begin fails++; $display("FAIL reset addr: got %0d expected 0", WriteAddress); end
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (2) @(negedge CLK);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL idle busy: got %b expected 0", Busy); end
    endtask

    task automatic test_mul;
        drive_op(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 1'b1, "mul_7x6");
        collect_results(60);
        drive_op(3'b000, 32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1, 1'b1, "mul_neg3x5");
        collect_results(60);
    endtask

    task automatic test_mulh;
        drive_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0, 1'b1, "mulh_m1xm1");
        collect_results(60);
        drive_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b1, "mulhu_max");
        collect_results(60);
        drive_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b1, "mulhsu_m1x2");
        collect_results(60);
        drive_op(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6, 32'h3FFF_FFFF, 1'b1, "mulh_maxpos");
        collect_results(60);
    endtask

    task automatic test_div;
        drive_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 1'b1, "div_m7_2");
        collect_results(60);
        drive_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 1'b1, "rem_m7_2");
        collect_results(60);
        drive_op(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1, "divu_100_7");
        collect_results(60);
        drive_op(3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 1'b1, "remu_100_7");
        collect_results(60);
    endtask

    task automatic test_div_special;
        drive_op(3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1, "div_5_0");
        collect_results(60);
        drive_op(3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 1'b1, "rem_5_0");
        collect_results(60);
        drive_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1, "div_ovf");
        collect_results(60);
        drive_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 1'b1, "rem_ovf");
        collect_results(60);
        drive_op(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFF, 1'b1, "div_m5_0");
        collect_results(60);
        drive_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd19, 32'hFFFF_FFFB, 1'b1, "rem_m5_0");
        collect_results(60);
        drive_op(3'b111, 32'h8000_0001, 32'd0, 5'd20, 32'h8000_0001, 1'b1, "remu_x_0");
        collect_results(60);
        drive_op(3'b001, 32'd0, 32'hFFFF_FFFF, 5'd21, 32'h0, 1'b1, "mulh_zero");
        collect_results(60);
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b  = (i % 4 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            drive_op(f3, a, b, 5'($urandom_range(1, 31)), ref_model(f3, a, b), 1'b1, "random");
            collect_results(60);
        end
    endtask

    task automatic test_ignore_start;
        int k, dones;
        drive_op(3'b000, 32'd1000, 32'd3000, 5'd7, 32'd0, 1'b0, "");
        k = cyc;
        dones = 0;
        for (int c = 0; c < 80; c++) begin
            if (Done === 1'b1) begin
                dones++;
                tests++;
                if (WriteData !== 32'd3000000 || cyc !== k + 33) begin
                    fails++;
                    $display("FAIL ignore_start result: got %h at cycle %0d expected %h at %0d",
                             WriteData, cyc, 32'd3000000, k + 33);
                end
            end
            if (cyc == k + 10 || Done === 1'b1) begin
                Start = 1'b1; Funct3 = 3'b101; Operand1 = 32'd9; Operand2 = 32'd3; Rd = 5'd8;
            end else begin
                Start = 1'b0;
            end
            @(negedge CLK);
        end
        Start = 1'b0;
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL ignore_start done count: got %0d expected 1", dones);
        end
        drive_op(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1, "rd_zero");
        collect_results(60);
    endtask

    task automatic test_reset_midop;
        int k, dones;
        drive_op(3'b000, 32'd11, 32'd13, 5'd9, 32'd0, 1'b0, "");
        k = cyc;
        while (cyc < k + 10) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || WriteEn !== 1'b0 || WriteData !== 32'h0 || WriteAddress !== 5'd0) begin
            fails++;
            $display("FAIL midop_reset outputs: busy=%b done=%b wen=%b data=%h addr=%0d expected all 0",
                     Busy, Done, WriteEn, WriteData, WriteAddress);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge CLK);
            if (Done === 1'b1 || WriteEn === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL midop_reset writeback: got %0d done cycles expected 0", dones);
        end
        drive_op(3'b000, 32'd11, 32'd13, 5'd9, 32'd143, 1'b1, "after_reset");
        collect_results(60);
    endtask

    task automatic test_back_to_back;
        drive_op(3'b101, 32'd1000, 32'd10, 5'd3, 32'd100, 1'b1, "b2b_first");
        collect_results(60);
        drive_op(3'b110, 32'd1000, 32'd7, 5'd4, 32'd6, 1'b1, "b2b_second");
        repeat (10) @(negedge CLK);
        tests++;
        if (WriteData !== 32'd100 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b hold: data=%h busy=%b expected %h and 1", WriteData, Busy, 32'd100);
        end
        collect_results(60);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_random();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
